fxp8s_pe_array_n: RTL and testbench
===================================

FXP8S_PE_ARRAY_N -- requirements
Module: fxp8s_pe_array_n

Interface
REQ-001 SHALL have parameter N, default 2, meaning matrix dimension and PE array is N x N (legal 2..8).
REQ-002 SHALL have parameter ACC_W, default 16, meaning signed accumulator width per PE (legal 12..24).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en_in_data  input  1  upstream beat valid.
REQ-006 SHALL have port rdy_in_data  output  1  block accepts in_data this cycle.
REQ-007 SHALL have port in_mat  input  1  target matrix: 0=A, 1=B.
REQ-008 SHALL have port in_new_row  input  1  current beat starts a new row.
REQ-009 SHALL have port in_mat_done  input  1  target matrix ends; pad remainder.
REQ-010 SHALL have port in_data  input  8  fxp8s operand (bit 7 sign, bits 6:0 magnitude, LSB 2^-3).
REQ-011 SHALL have port en_out_data  output  1  out_data valid.
REQ-012 SHALL have port rdy_out_data  input  1  downstream accepts.
REQ-013 SHALL have port out_mat  output  1  high on last element C[N-1][N-1].
REQ-014 SHALL have port out_new_row  output  1  high on element in column 0.
REQ-015 SHALL have port out_data  output  8  fxp8s result element, row-major.

Function
REQ-016 SHALL run FSM LOAD -> COMPUTE -> DRAIN -> LOAD; LOAD entered from reset.
REQ-017 LOAD: A and B each SHALL keep independent row/col counters; A and B beats may interleave in any order.
REQ-018 Transfer SHALL occur only when en_in_data & rdy_in_data; element stored at [row][col] of matrix in_mat, col advances, wraps at N-1 into row+1.
REQ-019 rdy_in_data SHALL be low when target matrix is full, when padding, or outside LOAD.
REQ-020 Beat with in_new_row while target col != 0 SHALL cause zero writes, one per cycle, to remaining columns; beat accepted after col returns to 0.
REQ-021 in_mat_done with en_in_data SHALL zero-fill the target matrix to [N-1][N-1], one element per cycle, consuming no data; no effect on full matrix.
REQ-022 COMPUTE SHALL start the cycle after both matrices are full and last exactly N cycles; step k: PE[i][j] += p(A[i][k], B[k][j]) for all i,j.
REQ-023 p SHALL be: magnitude = (|a|*|b|) >> 3 truncated, sign = sign(a) XOR sign(b), applied as two's complement into ACC_W; zero magnitude counts as +0.
REQ-024 Accumulators SHALL clear on entry to COMPUTE; ACC_W overflow wraps.
REQ-025 DRAIN SHALL present C in row-major order, en_out_data high throughout; element advances only on en_out_data & rdy_out_data; out_data/flags held stable while stalled.
REQ-026 Output conversion: negative result -> sign 1, magnitude |acc|; 0 -> 0x00.
REQ-027 After transfer of C[N-1][N-1] SHALL return to LOAD next cycle with A/B buffers and counters cleared; rdy_in_data may assert that cycle.
REQ-028 Result-to-first-output latency SHALL be N+1 cycles after the last input write.

Reset
REQ-029 rstn low SHALL immediately clear FSM to LOAD, all counters, buffers, accumulators; rdy_in_data, en_out_data, out_mat, out_new_row, out_data = 0.
REQ-030 Reset mid-COMPUTE or mid-DRAIN SHALL abort the operation; no partial results emitted after release.
REQ-031 First rdy_in_data SHALL assert no earlier than the first clk edge after rstn rises.

Configuration
REQ-032 Macro FXP8S_PE_ARRAY_SAT_EN defined: magnitude SHALL saturate to 127 when |acc| > 127.
REQ-033 Macro FXP8S_PE_ARRAY_SAT_EN undefined: magnitude SHALL be |acc| modulo 128 (low 7 bits).

Verification
REQ-034 N=2, A=[[08,00],[00,08]], B=[[10,81],[02,7F]] -> out 10,81,02,7F; out_new_row on 1st,3rd; out_mat on 4th.
REQ-035 N=2, A=[[88,08],...], B col0=[10,10] -> C[0][0]=0x00; A[0][0]=88,A[0][1]=00 -> C[0][0]=0x90.
REQ-036 N=2, all A,B=7F -> every C element 0x7F with SAT_EN, 0x40 without.
REQ-037 N=3, A row 0 sent as one beat 08 then in_new_row beat; then in_mat_done -> A rows padded with zeros, rdy_in_data low 2 cycles per pad, C matches zero-padded reference.
REQ-038 Stall rdy_out_data low 5 cycles mid-DRAIN -> out_data constant, no element lost or duplicated; rstn low during DRAIN -> en_out_data 0 immediately, rdy_in_data 1 after release.

Source files
------------

// File: rtl/fxp8s_pe_array_n.sv
// N x N fxp8s matrix-multiply PE array: loads A and B, accumulates C = A*B, streams C row-major.
// Optional macro FXP8S_PE_ARRAY_SAT_EN saturates output magnitudes to 127 instead of wrapping mod 128.
module fxp8s_pe_array_n #(
   parameter int N     = 2,
   parameter int ACC_W = 16
)(
   input  logic       clk,
   input  logic       rstn,
   input  logic       en_in_data,
   output logic       rdy_in_data,
   input  logic       in_mat,
   input  logic       in_new_row,
   input  logic       in_mat_done,
   input  logic [7:0] in_data,
   output logic       en_out_data,
   input  logic       rdy_out_data,
   output logic       out_mat,
   output logic       out_new_row,
   output logic [7:0] out_data
);
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_DRAIN} state_t;

   state_t                   state;
   logic                     ready_q;
   logic [7:0]               mem     [2][N][N];
   logic [CW-1:0]            row     [2];
   logic [CW-1:0]            col     [2];
   logic [1:0]               full, pad;
   logic [1:0]               wr, data_wr;
   logic [CW-1:0]            k_cnt, dr_row, dr_col, dr_nrow, dr_ncol;
   logic signed [ACC_W-1:0]  acc     [N][N];
   logic signed [ACC_W-1:0]  acc_nxt [N][N];
   logic                     load_act, nr_pad;

   function automatic logic signed [ACC_W-1:0] fxp_mul(input logic [7:0] a, input logic [7:0] b);
      logic [13:0]             prod;
      logic signed [ACC_W-1:0] mag;
      prod = 14'(a[6:0]) * 14'(b[6:0]);
      mag  = ACC_W'(prod >> 3);
      return (a[7] ^ b[7]) ? -mag : mag;
   endfunction

   function automatic logic [7:0] to_fxp8s(input logic signed [ACC_W-1:0] v);
      logic       neg;
      logic [6:0] m7;
`ifdef FXP8S_PE_ARRAY_SAT_EN
      logic [ACC_W-1:0] mag;
`endif
      neg = v[ACC_W-1];
`ifdef FXP8S_PE_ARRAY_SAT_EN
      mag = neg ? ACC_W'(-v) : ACC_W'(v);
      m7  = (mag > ACC_W'(127)) ? 7'h7F : mag[6:0];
`else
      m7  = neg ? 7'(-v) : v[6:0];
`endif
      return (m7 == '0) ? 8'h00 : {neg, m7};
   endfunction

   // Each matrix writes at most one element per cycle: a data beat, or a zero from row/matrix padding.
   always_comb begin
      load_act    = (state == S_LOAD) && ready_q;
      nr_pad      = in_new_row && (col[in_mat] != '0);
      rdy_in_data = load_act && !full[in_mat] && !pad[in_mat] && !in_mat_done && !nr_pad;
      data_wr     = '0;
      wr          = '0;
      for (int unsigned m = 0; m < 2; m++) begin
         data_wr[m] = en_in_data && rdy_in_data && (in_mat == 1'(m));
         wr[m]      = data_wr[m] ||
                      (load_act && !full[m] &&
                       (pad[m] || (en_in_data && (in_mat == 1'(m)) && (in_mat_done || nr_pad))));
      end
   end

   always_comb begin
      if (dr_col == LAST) begin
         dr_nrow = dr_row + 1'b1;
         dr_ncol = '0;
      end else begin
         dr_nrow = dr_row;
         dr_ncol = dr_col + 1'b1;
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < N; i++)
         for (int unsigned j = 0; j < N; j++)
            acc_nxt[i][j] = acc[i][j] + fxp_mul(mem[0][i][k_cnt], mem[1][k_cnt][j]);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= S_LOAD;
         ready_q     <= 1'b0;
         full        <= '0;
         pad         <= '0;
         k_cnt       <= '0;
         dr_row      <= '0;
         dr_col      <= '0;
         en_out_data <= 1'b0;
         out_mat     <= 1'b0;
         out_new_row <= 1'b0;
         out_data    <= '0;
         for (int unsigned m = 0; m < 2; m++) begin
            row[m] <= '0;
            col[m] <= '0;
            for (int unsigned i = 0; i < N; i++)
               for (int unsigned j = 0; j < N; j++)
                  mem[m][i][j] <= '0;
         end
         for (int unsigned i = 0; i < N; i++)
            for (int unsigned j = 0; j < N; j++)
               acc[i][j] <= '0;
      end else begin
         ready_q <= 1'b1;
         case (state)
            S_LOAD: begin
               for (int unsigned m = 0; m < 2; m++) begin
                  if (en_in_data && in_mat_done && (in_mat == 1'(m)) && load_act && !full[m])
                     pad[m] <= 1'b1;
                  if (wr[m]) begin
                     mem[m][row[m]][col[m]] <= data_wr[m] ? in_data : 8'h00;
                     if (col[m] == LAST) begin
                        col[m] <= '0;
                        if (row[m] == LAST) begin
                           full[m] <= 1'b1;
                           pad[m]  <= 1'b0;
                        end else begin
                           row[m] <= row[m] + 1'b1;
                        end
                     end else begin
                        col[m] <= col[m] + 1'b1;
                     end
                  end
               end
               if (full == 2'b11) begin
                  state <= S_COMPUTE;
                  k_cnt <= '0;
                  for (int unsigned i = 0; i < N; i++)
                     for (int unsigned j = 0; j < N; j++)
                        acc[i][j] <= '0;
               end
            end
            S_COMPUTE: begin
               for (int unsigned i = 0; i < N; i++)
                  for (int unsigned j = 0; j < N; j++)
                     acc[i][j] <= acc_nxt[i][j];
               if (k_cnt == LAST) begin
                  // C[0][0] is taken from the final sum so it is registered as DRAIN begins
                  state       <= S_DRAIN;
                  dr_row      <= '0;
                  dr_col      <= '0;
                  en_out_data <= 1'b1;
                  out_new_row <= 1'b1;
                  out_mat     <= 1'b0;
                  out_data    <= to_fxp8s(acc_nxt[0][0]);
               end else begin
                  k_cnt <= k_cnt + 1'b1;
               end
            end
            S_DRAIN: begin
               if (rdy_out_data) begin
                  if (dr_row == LAST && dr_col == LAST) begin
                     state       <= S_LOAD;
                     en_out_data <= 1'b0;
                     out_mat     <= 1'b0;
                     out_new_row <= 1'b0;
                     out_data    <= '0;
                     full        <= '0;
                     pad         <= '0;
                     for (int unsigned m = 0; m < 2; m++) begin
                        row[m] <= '0;
                        col[m] <= '0;
                        for (int unsigned i = 0; i < N; i++)
                           for (int unsigned j = 0; j < N; j++)
                              mem[m][i][j] <= '0;
                     end
                  end else begin
                     dr_row      <= dr_nrow;
                     dr_col      <= dr_ncol;
                     out_new_row <= (dr_ncol == '0);
                     out_mat     <= (dr_nrow == LAST) && (dr_ncol == LAST);
                     out_data    <= to_fxp8s(acc[dr_nrow][dr_ncol]);
                  end
               end
            end
            default: state <= S_LOAD;
         endcase
      end
   end
endmodule

// File: tb/tb_fxp8s_pe_array_n.sv
// Directed bench for fxp8s_pe_array_n: N=2 vector table plus stall/reset sequences and an N=3 padding case.
module tb_fxp8s_pe_array_n;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rstn;

   logic en_in, rdy_in, in_mat, in_nr, in_done, en_out, rdy_out, out_mat, out_nr;
   logic [7:0] in_data, out_data;
   logic en_in3, rdy_in3, in_mat3, in_nr3, in_done3, en_out3, rdy_out3, out_mat3, out_nr3;
   logic [7:0] in_data3, out_data3;

   int n_tests = 0;
   int n_fail  = 0;

   fxp8s_pe_array_n #(.N(2), .ACC_W(16)) u_dut2 (
      .clk(clk), .rstn(rstn), .en_in_data(en_in), .rdy_in_data(rdy_in), .in_mat(in_mat),
      .in_new_row(in_nr), .in_mat_done(in_done), .in_data(in_data), .en_out_data(en_out),
      .rdy_out_data(rdy_out), .out_mat(out_mat), .out_new_row(out_nr), .out_data(out_data));

   fxp8s_pe_array_n #(.N(3), .ACC_W(16)) u_dut3 (
      .clk(clk), .rstn(rstn), .en_in_data(en_in3), .rdy_in_data(rdy_in3), .in_mat(in_mat3),
      .in_new_row(in_nr3), .in_mat_done(in_done3), .in_data(in_data3), .en_out_data(en_out3),
      .rdy_out_data(rdy_out3), .out_mat(out_mat3), .out_new_row(out_nr3), .out_data(out_data3));

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
   } vec_t;
   vec_t vecs [5];

`ifdef FXP8S_PE_ARRAY_SAT_EN
   localparam logic [31:0] ALL7F_EXP = 32'h7F7F7F7F;
`else
   localparam logic [31:0] ALL7F_EXP = 32'h40404040;
`endif

   function automatic logic [7:0] el(input logic [31:0] x, input int k);
      return x[31 - 8*k -: 8];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got timeout expected handshake", name);
   endtask

   task automatic send2(input logic mat, input logic nr, input logic [7:0] d);
      int cyc = 0;
      @(negedge clk);
      en_in = 1'b1; in_mat = mat; in_nr = nr; in_done = 1'b0; in_data = d;
      #1;
      while (!rdy_in && cyc < 20) begin @(negedge clk); #1; cyc++; end
      if (!rdy_in) timeout("send2");
      @(posedge clk);
      #1 en_in = 1'b0;
   endtask

   task automatic send3(input logic mat, input logic nr, input logic [7:0] d, output int lowc);
      int cyc = 0;
      @(negedge clk);
      en_in3 = 1'b1; in_mat3 = mat; in_nr3 = nr; in_done3 = 1'b0; in_data3 = d;
      #1;
      while (!rdy_in3 && cyc < 20) begin @(negedge clk); #1; cyc++; end
      if (!rdy_in3) timeout("send3");
      lowc = cyc;
      @(posedge clk);
      #1 en_in3 = 1'b0;
   endtask

   task automatic load2(input logic [31:0] a, input logic [31:0] b);
      for (int k = 0; k < 4; k++) begin
         send2(1'b0, (k % 2) == 0, el(a, k));
         send2(1'b1, (k % 2) == 0, el(b, k));
      end
   endtask

   task automatic wait_out2(input string name, input int exp_lat);
      int lat = 0;
      while (!en_out && lat < 20) begin @(posedge clk); #1; lat++; end
      check(name, 32'(lat), 32'(exp_lat));
   endtask

   task automatic collect2(input logic [31:0] c, input string tag);
      int cyc;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         cyc = 0;
         while (!en_out && cyc < 20) begin @(negedge clk); cyc++; end
         check($sformatf("%s_data%0d", tag, k), 32'(out_data), 32'(el(c, k)));
         check($sformatf("%s_flags%0d", tag, k), {30'd0, out_nr, out_mat},
               {30'd0, (k % 2) == 0, k == 3});
      end
      @(negedge clk);
      check($sformatf("%s_back_to_load", tag), {30'd0, en_out, rdy_in}, 32'h1);
   endtask

   initial begin
      int lowc;
      int lat;
      logic bad;
      logic [7:0] b3 [9];
      logic [7:0] c3 [9];

      vecs[0] = '{a: 32'h08000008, b: 32'h1081027F, c: 32'h1081027F};
      vecs[1] = '{a: 32'h88080000, b: 32'h10081018, c: 32'h00100000};
      vecs[2] = '{a: 32'h88000000, b: 32'h10081018, c: 32'h90880000};
      vecs[3] = '{a: 32'h7F7F7F7F, b: 32'h7F7F7F7F, c: ALL7F_EXP};
      vecs[4] = '{a: 32'h0B83850C, b: 32'h078A0906, c: 32'h068F090F};
      b3 = '{8'h05, 8'h83, 8'h20, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      c3 = '{8'h05, 8'h83, 8'h20, 8'h0A, 8'h86, 8'h40, 8'h00, 8'h00, 8'h00};

      rstn = 1'b0;
      en_in = 1'b0; in_mat = 1'b0; in_nr = 1'b0; in_done = 1'b0; in_data = '0; rdy_out = 1'b1;
      en_in3 = 1'b0; in_mat3 = 1'b0; in_nr3 = 1'b0; in_done3 = 1'b0; in_data3 = '0; rdy_out3 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", {20'd0, rdy_in, en_out, out_mat, out_nr, out_data}, 32'h0);
      @(negedge clk) rstn = 1'b1;
      #1 check("rdy_before_first_edge", 32'(rdy_in), 32'h0);
      @(posedge clk);
      #1 check("rdy_after_first_edge", 32'(rdy_in), 32'h1);

      for (int i = 0; i < 5; i++) begin
         load2(vecs[i].a, vecs[i].b);
         wait_out2($sformatf("v%0d_latency", i), 3);
         collect2(vecs[i].c, $sformatf("v%0d", i));
      end

      // output stall: element 1 held for five cycles
      load2(vecs[4].a, vecs[4].b);
      wait_out2("stall_latency", 3);
      @(negedge clk) check("stall_e0", 32'(out_data), 32'h06);
      @(negedge clk) check("stall_e1", 32'(out_data), 32'h8F);
      rdy_out = 1'b0;
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         check($sformatf("stall_hold%0d", s), {23'd0, en_out, out_data}, {23'd0, 1'b1, 8'h8F});
      end
      rdy_out = 1'b1;
      @(negedge clk) check("stall_e2", {22'd0, out_nr, out_mat, out_data}, {22'd0, 2'b10, 8'h09});
      @(negedge clk) check("stall_e3", {22'd0, out_nr, out_mat, out_data}, {22'd0, 2'b01, 8'h0F});
      @(negedge clk) check("stall_done", 32'(en_out), 32'h0);

      // reset in the middle of DRAIN
      load2(vecs[0].a, vecs[0].b);
      wait_out2("rst_latency", 3);
      @(negedge clk) check("rst_e0", 32'(out_data), 32'h10);
      @(posedge clk);
      #2 rstn = 1'b0;
      #1 check("rst_en_out_immediate", {23'd0, en_out, out_data}, 32'h0);
      @(negedge clk) rstn = 1'b1;
      #1 check("rst_rdy_before_edge", 32'(rdy_in), 32'h0);
      @(posedge clk);
      #1 check("rst_rdy_after_edge", 32'(rdy_in), 32'h1);
      bad = 1'b0;
      repeat (6) begin @(posedge clk); #1 if (en_out) bad = 1'b1; end
      check("rst_no_partial_output", 32'(bad), 32'h0);
      load2(vecs[1].a, vecs[1].b);
      wait_out2("post_rst_latency", 3);
      collect2(vecs[1].c, "post_rst");

      // N=3: short row padded by in_new_row, rest of A padded by in_mat_done
      send3(1'b0, 1'b1, 8'h08, lowc);
      send3(1'b0, 1'b1, 8'h10, lowc);
      check("n3_new_row_pad_cycles", 32'(lowc), 32'd2);
      @(negedge clk);
      en_in3 = 1'b1; in_mat3 = 1'b0; in_done3 = 1'b1; in_nr3 = 1'b0;
      @(posedge clk);
      #1 en_in3 = 1'b0; in_done3 = 1'b0;
      check("n3_done_pad_rdy_low", 32'(rdy_in3), 32'h0);
      for (int k = 0; k < 9; k++) send3(1'b1, (k % 3) == 0, b3[k], lowc);
      lat = 0;
      while (!en_out3 && lat < 30) begin @(posedge clk); #1; lat++; end
      check("n3_latency", 32'(lat), 32'd4);
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         check($sformatf("n3_data%0d", k), 32'(out_data3), 32'(c3[k]));
         check($sformatf("n3_flags%0d", k), {29'd0, en_out3, out_nr3, out_mat3},
               {29'd0, 1'b1, (k % 3) == 0, k == 8});
      end
      @(negedge clk) check("n3_back_to_load", {30'd0, en_out3, rdy_in3}, 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
